sr_ff_arbiter: RTL and testbench

- Round-robin controller that shares one SR flip-flop (s/r/clk in, q_out/qbar_out back) among N requesters.
- Each requester asks to set or clear the flop.
- The arbiter grants one requester at a time and drives s/r for a timed pulse.
- It then releases s/r, optionally checks q_out/qbar_out, and acknowledges.
- By construction s and r are never both driven to 1.

---
 rtl/sr_ff_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sr_ff_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_arbiter.sv
// Round-robin arbiter sharing one external SR flop among N requesters.
// Optional readback check enabled with `define SR_READBACK_CHECK_EN.
module sr_ff_arbiter #(
  parameter int N         = 4,
  parameter int PULSE_LEN = 1,
  parameter int PTR_W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] op,
  output logic [N-1:0] gnt,
  output logic [N-1:0] ack,
  output logic         ff_s,
  output logic         ff_r,
  input  logic         ff_q,
  input  logic         ff_qbar,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ACK} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   w_q, w_d;
  logic               op_q, op_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [N-1:0]       ack_q, ack_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W:0]     idx;

  // Scan from the pointer upward, wrapping, so the last winner ends up last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  assign ptr_next = (w_q == PTR_W'(N-1)) ? '0 : w_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    s_d     = s_q;
    r_d     = r_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          w_d     = win;
          op_d    = op[win];
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
          busy_d  = 1'b1;
          s_d     = op[win];
          r_d     = ~op[win];
          cnt_d   = 4'(PULSE_LEN-1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SETTLE: begin
        ack_d   = gnt_q;
        state_d = ACK;
      end
      ACK: begin
        ack_d   = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SR_READBACK_CHECK_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       mismatch;

  // The flop has had a full s=r=0 cycle to settle by the end of SETTLE.
  always_comb begin
    mismatch  = (ff_q != op_q) || (ff_qbar != ~ff_q);
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (state_q == SETTLE && mismatch) begin
      err_d     = 1'b1;
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err = err_q;
`else
  logic unused_readback;
  assign unused_readback = ff_q ^ ff_qbar;
  assign err = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign ff_s = s_q;
  assign ff_r = r_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sr_ff_arbiter.sv
// Bench for sr_ff_arbiter: two instances (PULSE_LEN 1 and 3), each with an SR flop model,
// a phase-based reference model checked every cycle, and directed literal checks.
module tb_sr_ff_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a [2];
  logic [3:0] op_a  [2];
  logic [3:0] gnt_a [2];
  logic [3:0] ack_a [2];
  logic       s_a [2], r_a [2], busy_a [2], err_a [2];
  logic       q_a [2], qin_a [2], qbar_a [2];
  logic       force_q0 [2];

  int vectors = 0;
  int miscompares = 0;

  bit m_busy [2];
  bit m_op   [2];
  bit m_err  [2];
  int m_t [2], m_w [2], m_ptr [2], m_cnt [2];

  logic [3:0] gl [8];
  int gt [8];
  int gn;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_ff_arbiter #(.N(4), .PULSE_LEN(1), .PTR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_a[0]), .op(op_a[0]), .gnt(gnt_a[0]), .ack(ack_a[0]),
    .ff_s(s_a[0]), .ff_r(r_a[0]), .ff_q(qin_a[0]), .ff_qbar(qbar_a[0]),
    .busy(busy_a[0]), .err(err_a[0]));

  sr_ff_arbiter #(.N(4), .PULSE_LEN(3), .PTR_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_a[1]), .op(op_a[1]), .gnt(gnt_a[1]), .ack(ack_a[1]),
    .ff_s(s_a[1]), .ff_r(r_a[1]), .ff_q(qin_a[1]), .ff_qbar(qbar_a[1]),
    .busy(busy_a[1]), .err(err_a[1]));

  assign qin_a[0]  = force_q0[0] ? 1'b0 : q_a[0];
  assign qin_a[1]  = force_q0[1] ? 1'b0 : q_a[1];
  assign qbar_a[0] = ~q_a[0];
  assign qbar_a[1] = ~q_a[1];

  // Clocked SR flops; power-up values differ so a clear on dut3 is observable.
  always @(posedge clk) begin
    if (s_a[0]) q_a[0] <= 1'b1;
    else if (r_a[0]) q_a[0] <= 1'b0;
    else if ($isunknown(q_a[0])) q_a[0] <= 1'b0;
    if (s_a[1]) q_a[1] <= 1'b1;
    else if (r_a[1]) q_a[1] <= 1'b0;
    else if ($isunknown(q_a[1])) q_a[1] <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an operation is a timeline of PL+2 cycles after the grant edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          m_busy[i] = 1'b0; m_ptr[i] = 0; m_err[i] = 1'b0; m_cnt[i] = 0; m_t[i] = 0;
        end
      end
`ifdef SR_READBACK_CHECK_EN
      chk("err_cnt[0]", 32'(dut1.err_cnt_q), 32'(m_cnt[0]));
      chk("err_cnt[1]", 32'(dut3.err_cnt_q), 32'(m_cnt[1]));
`endif
      for (int i = 0; i < 2; i++) begin
        int pl;
        logic [3:0] eg;
        pl = (i == 0) ? 1 : 3;
        eg = m_busy[i] ? 4'(1 << m_w[i]) : 4'd0;
        chk($sformatf("gnt[%0d]", i), 32'(gnt_a[i]), 32'(eg));
        chk($sformatf("ack[%0d]", i), 32'(ack_a[i]), (m_busy[i] && m_t[i] == pl+1) ? 32'(eg) : 32'd0);
        chk($sformatf("ff_s[%0d]", i), 32'(s_a[i]), 32'(m_busy[i] && m_t[i] < pl && m_op[i]));
        chk($sformatf("ff_r[%0d]", i), 32'(r_a[i]), 32'(m_busy[i] && m_t[i] < pl && !m_op[i]));
        chk($sformatf("busy[%0d]", i), 32'(busy_a[i]), 32'(m_busy[i]));
        chk($sformatf("s_and_r[%0d]", i), 32'(s_a[i] & r_a[i]), 32'd0);
`ifdef SR_READBACK_CHECK_EN
        chk($sformatf("err[%0d]", i), 32'(err_a[i]), 32'(m_err[i]));
`else
        chk($sformatf("err[%0d]", i), 32'(err_a[i]), 32'd0);
`endif
        if (rst_n) begin
          if (!m_busy[i]) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
              int idx;
              idx = (m_ptr[i] + k) % 4;
              if (!found && req_a[i][idx]) begin
                found = 1'b1; m_w[i] = idx;
              end
            end
            if (found) begin
              m_busy[i] = 1'b1; m_t[i] = 0; m_op[i] = op_a[i][m_w[i]];
            end
          end else begin
            if (m_t[i] == pl) begin
              if (qin_a[i] !== m_op[i] || qbar_a[i] !== ~qin_a[i]) begin
                m_err[i] = 1'b1;
                if (m_cnt[i] < 255) m_cnt[i]++;
              end
            end
            m_t[i]++;
            if (m_t[i] == pl + 2) begin
              m_busy[i] = 1'b0; m_ptr[i] = (m_w[i] + 1) % 4;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs instance i until its requests are served, recording each new grant.
  task automatic run_drain(input int i, input int budget);
    logic [3:0] prev;
    bit done;
    int st;
    prev = gnt_a[i];
    done = 1'b0;
    gn = 0;
    st = 0;
    while (!done && st < budget) begin
      step();
      st++;
      if (gnt_a[i] != 4'd0 && prev == 4'd0 && gn < 8) begin
        gl[gn] = gnt_a[i]; gt[gn] = st; gn++;
      end
      prev = gnt_a[i];
      req_a[i] = req_a[i] & ~ack_a[i];
      if (req_a[i] == 4'd0 && !busy_a[i]) done = 1'b1;
    end
    chk($sformatf("drain_done[%0d]", i), 32'(done), 32'd1);
  endtask

  initial begin
    int rc, ackst;
    logic [3:0] ackv;
    req_a[0] = '0; req_a[1] = '0; op_a[0] = '0; op_a[1] = '0;
    force_q0[0] = 1'b0; force_q0[1] = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset
    repeat (10) begin
      step();
      chk("idle_outs", {gnt_a[0], ack_a[0], s_a[0], r_a[0], busy_a[0]}, 32'd0);
    end

    // Single set request on requester 0
    req_a[0] = 4'b0001; op_a[0] = 4'b0001;
    step();
    chk("single_gnt", 32'(gnt_a[0]), 32'h1);
    chk("single_s_hi", 32'(s_a[0]), 32'd1);
    step();
    chk("single_s_lo", 32'(s_a[0]), 32'd0);
    step();
    chk("single_ack", 32'(ack_a[0]), 32'h1);
    req_a[0] = 4'b0000;
    step();
    chk("single_ack_lo", 32'(ack_a[0]), 32'd0);
    chk("single_q", 32'(q_a[0]), 32'd1);
    chk("single_err", 32'(err_a[0]), 32'd0);

    // Reset mid-DRIVE: pointer is 1, so 1001 first grants bit 3
    req_a[0] = 4'b1001; op_a[0] = 4'b1001;
    step();
    chk("pre_rst_gnt", 32'(gnt_a[0]), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt_a[0]), 32'd0);
    chk("rst_sr", 32'({s_a[0], r_a[0]}), 32'd0);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 32'(gnt_a[0]), 32'h1);
    run_drain(0, 30);
    chk("post_rst_n", 32'(gn), 32'd1);
    chk("post_rst_second", 32'(gl[0]), 32'h8);

    // All four requesting: round-robin order, 4 cycles apart
    req_a[0] = 4'b1111; op_a[0] = 4'b1010;
    run_drain(0, 60);
    chk("rr_count", 32'(gn), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_gnt%0d", k), 32'(gl[k]), 32'(1 << k));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gt[k] - gt[k-1]), 32'd4);
    end
    chk("rr_final_q", 32'(q_a[0]), 32'd1);

    // PULSE_LEN=3 clear on requester 2
    req_a[1] = 4'b0100; op_a[1] = 4'b0000;
    rc = 0; ackst = 0; ackv = '0;
    for (int st = 1; st <= 12; st++) begin
      step();
      if (r_a[1]) rc++;
      if (ack_a[1] != 4'd0) begin
        ackst = st; ackv = ack_a[1]; req_a[1] = 4'b0000;
      end
    end
    chk("pl3_r_cycles", 32'(rc), 32'd3);
    chk("pl3_ack_step", 32'(ackst), 32'd5);
    chk("pl3_ack_val", 32'(ackv), 32'h4);
    chk("pl3_q", 32'(q_a[1]), 32'd0);

    // Forced bad readback during a set, then a good operation
    force_q0[0] = 1'b1;
    req_a[0] = 4'b0001; op_a[0] = 4'b0001;
    run_drain(0, 30);
    force_q0[0] = 1'b0;
`ifdef SR_READBACK_CHECK_EN
    chk("rb_err", 32'(err_a[0]), 32'd1);
    chk("rb_cnt", 32'(dut1.err_cnt_q), 32'd1);
`else
    chk("rb_err", 32'(err_a[0]), 32'd0);
`endif
    req_a[0] = 4'b0010; op_a[0] = 4'b0010;
    run_drain(0, 30);
`ifdef SR_READBACK_CHECK_EN
    chk("rb_err_sticky", 32'(err_a[0]), 32'd1);
    chk("rb_cnt_hold", 32'(dut1.err_cnt_q), 32'd1);
`else
    chk("rb_err_sticky", 32'(err_a[0]), 32'd0);
`endif
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
